priority_dec: RTL
=================

# priority_dec

Sequential 3-to-8 decoder with enable, the decode-side counterpart of the team's 8-to-3 priority encoder. It accepts 3-bit codes over a valid/ready handshake and regenerates a one-hot 8-bit request vector. Each vector is held for a programmable number of cycles, so downstream request lines see a stable, timed assertion. It sits after an encoded request channel and drives per-line request/strobe inputs.

## Interface
- HOLD_CYCLES, 4, cycles each decoded one-hot vector is held on `a`; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy HOLD_CYCLES-1 < 2**CNT_W.

- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- en  input  1  decoder enable; 0 forces output clear and blocks acceptance.
- y  input  3  encoded index to decode.
- y_valid  input  1  `y` holds a code to be accepted.
- y_ready  output  1  block can accept `y` this cycle (combinational).
- a  output  8  registered one-hot decoded vector; all-zero when idle or disabled.
- a_valid  output  1  registered; high while `a` carries a held vector.
- done  output  1  registered one-cycle pulse in the final hold cycle of each vector.

## Operation
- States (package enum): IDLE, HOLD.
- Accept condition: `y_valid && y_ready` at a rising edge.
- `y_ready = en && !rst && (state==IDLE || (state==HOLD && cnt==0))`.
- IDLE + accept: `a <= 8'b1 << y`, `a_valid <= 1`, `cnt <= HOLD_CYCLES-1`, go to HOLD.
- IDLE, no accept: `a = 0`, `a_valid = 0`.
- HOLD, cnt>0: `a` unchanged, cnt decrements by 1, `y_ready = 0`.
- HOLD, cnt==0 + accept: back-to-back reload with the new code; stay in HOLD; no zero gap on `a`.
- HOLD, cnt==0, no accept: `a <= 0`, `a_valid <= 0`, go to IDLE.
- `done` is 1 in the cycle where state==HOLD and cnt==0, whether or not a reload follows.
- en=0 (any state): next edge sets `a <= 0`, `a_valid <= 0`, `cnt <= 0`, state <= IDLE, `done <= 0`. An in-flight vector is aborted with no `done`. `y_ready` is 0, so no code is consumed.
- Any 3-bit value of `y` is legal; `a` is always exactly one-hot (`$onehot(a)`) when `a_valid`=1.
- The counter never wraps: it decrements only while nonzero.

## Timing
- Reset values: `a = 8'b0`, `a_valid = 0`, `done = 0`, state = IDLE, cnt = 0. Reset overrides en and handshake. A reset during HOLD clears everything at that edge.
- Latency: a code accepted at edge k appears on `a` from edge k (registered) through HOLD_CYCLES cycles. It is visible in cycles k+1 .. k+HOLD_CYCLES.
- Throughput: one code per HOLD_CYCLES cycles sustained. HOLD_CYCLES=1 gives a new code every cycle with `y_ready` held high and `done` high every cycle.
- `y_ready` depends on en, state and cnt only, never on `y_valid` (no combinational loop).
- Simultaneous en falling and `y_valid` high: no accept, the clear wins.
- Simultaneous rst and accept: rst wins, code not consumed.

## Structure
- `priority_dec_pkg` holds:
  - the state enum (IDLE, HOLD);
  - `CODE_W = 3`;
  - `VEC_W = 8`;
  - a `function onehot_of(code)` returning `VEC_W` bits.
- One natural sub-module: `dec3to8` (combinational, `code` -> one-hot). It is instantiated once, feeding the `a` register's load mux. It is shared with future decode users.
- Top holds the FSM, counter, output registers and ready logic.

## Test plan
- Reset then en=1, y=3'd5 valid one cycle, HOLD_CYCLES=4 -> `a=8'b00100000`, `a_valid=1` for 4 cycles; `done` in 4th; then `a=0`, `a_valid=0`.
- y_valid held high, y sequence 0,1,7, HOLD_CYCLES=4 -> `a` = 00000001 ×4, 00000010 ×4, 10000000 ×4 with no gap; `y_ready` high only in each 4th cycle; `done` ×3.
- HOLD_CYCLES=1, y stepping 0..7 every cycle -> `a` walks 1,2,4,…,128 one per cycle; `y_ready` and `done` constantly 1.
- en dropped during 2nd hold cycle of y=3'd2 -> next edge `a=0`, `a_valid=0`, no `done`. With en=0 and y_valid=1, `y_ready=0` and no change. Re-enable accepts the pending code.
- rst asserted mid-HOLD with y_valid=1 -> all outputs 0 at that edge, state IDLE. First cycle after reset release, `y_ready=1` and the code is accepted.
- Random 200 codes with random y_valid/en gaps -> scoreboard: each accepted code appears one-hot for exactly HOLD_CYCLES cycles unless aborted by en/rst. `a` is never multi-hot.

Source files
------------

// File: rtl/priority_dec_pkg.sv
// priority_dec_pkg: shared types and helpers for the 3-to-8 decode path.
//   CODE_W    - width of an encoded request index
//   VEC_W     - width of the regenerated one-hot request vector
//   state_e   - decoder control states (IDLE, HOLD)
//   onehot_of - maps a code to its one-hot vector
package priority_dec_pkg;

  localparam int CODE_W = 3;
  localparam int VEC_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  function automatic logic [VEC_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
    return VEC_W'(1) << code;
  endfunction

endpackage

// File: rtl/priority_dec_dec3to8.sv
// dec3to8: combinational 3-to-8 one-hot decoder, shared by decode users.
//   code - encoded index (CODE_W bits)
//   vec  - one-hot vector with bit `code` set (VEC_W bits)
module dec3to8
  import priority_dec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [VEC_W-1:0]  vec
);

  assign vec = onehot_of(code);

endmodule

// File: rtl/priority_dec.sv
// priority_dec: sequential 3-to-8 decoder with enable. Accepts a code over a
// valid/ready handshake and holds the one-hot vector on `a` for HOLD_CYCLES
// cycles, pulsing `done` in the final hold cycle. Back-to-back codes reload
// with no zero gap on `a`.
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   en      - enable; low clears the output and blocks acceptance
//   y       - encoded index
//   y_valid - `y` carries a code
//   y_ready - code can be accepted this cycle (combinational)
//   a       - registered one-hot vector, zero when idle/disabled
//   a_valid - registered, high while `a` carries a held vector
//   done    - registered pulse in the final hold cycle of each vector
module priority_dec
  import priority_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CODE_W-1:0] y,
  input  logic              y_valid,
  output logic              y_ready,
  output logic [VEC_W-1:0]  a,
  output logic              a_valid,
  output logic              done
);

  // Counter holds the number of hold cycles remaining after the current one.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic               a_valid_q, a_valid_d;
  logic               done_q, done_d;
  logic [VEC_W-1:0]   dec_vec;
  logic               accept;

  dec3to8 u_dec (
    .code (y),
    .vec  (dec_vec)
  );

  // Ready depends only on en, rst, state and counter, so an upstream that
  // derives y_valid from y_ready cannot form a combinational loop.
  assign y_ready = en && !rst &&
                   ((state_q == IDLE) || ((state_q == HOLD) && (cnt_q == '0)));
  assign accept  = y_valid && y_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;

    if (!en) begin
      // Disable aborts any in-flight vector without a done pulse.
      state_d   = IDLE;
      cnt_d     = '0;
      a_d       = '0;
      a_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = HOLD;
            cnt_d     = CNT_LOAD;
            a_d       = dec_vec;
            a_valid_d = 1'b1;
          end else begin
            a_d       = '0;
            a_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (accept) begin
            // Reload in the final hold cycle: no idle gap between vectors.
            cnt_d     = CNT_LOAD;
            a_d       = dec_vec;
            a_valid_d = 1'b1;
          end else begin
            state_d   = IDLE;
            a_d       = '0;
            a_valid_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_d     = '0;
          a_d       = '0;
          a_valid_d = 1'b0;
        end
      endcase
    end

    // done is registered, so it is set one edge early: high whenever the
    // next cycle is the final hold cycle.
    done_d = (state_d == HOLD) && (cnt_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      done_q    <= done_d;
    end
  end

  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign done    = done_q;

endmodule
